// File: rtl/imem_loader_if.sv
// Byte-stream handshake bundle feeding the instruction-memory loader.
// Ports: byte_valid/byte_data from the source, byte_ready back from the loader.
interface imem_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> sequential 32-bit imem writes, then
// releases the core (load) on a good checksum or latches error otherwise.
// Ports: clk, areset (sync, active-high), start pulse, bs (byte stream
// slave), imem_we/imem_addr/imem_wdata write port, load, error, busy,
// words_written (words written in the current frame).
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start,
    imem_loader_if.slave          bs,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  load,
    output logic                  error,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int CAP = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CHK, RUN, ERR
    } state_t;

    state_t state, state_nx;

    logic [7:0]          len_lo;
    logic [ADDR_WIDTH:0] n_words;
    logic [1:0]          byte_idx;
    logic [23:0]         asm_q;
    logic [7:0]          xor_q;
    logic                xfer;
    logic [16:0]         len_full;
    logic                last_word;

    assign xfer      = bs.byte_valid && bs.byte_ready;
    assign len_full  = {1'b0, bs.byte_data, len_lo};
    assign last_word = (words_written + ONE) == n_words;

    // Handshake and status outputs are pure decodes of the state register.
    assign bs.byte_ready = (state == LEN0) || (state == LEN1) ||
                           (state == DATA) || (state == CHK);
    assign busy  = bs.byte_ready;
    assign load  = (state == RUN);
    assign error = (state == ERR);

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LEN0;
            end
            LEN0: begin
                if (xfer) state_nx = LEN1;
            end
            LEN1: begin
                if (xfer) begin
                    // Lengths beyond capacity are rejected up front so the
                    // write address can never wrap.
                    if (len_full > 17'(CAP)) begin
                        state_nx = ERR;
                    end else if (len_full == 17'd0) begin
                        state_nx = CHK;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && byte_idx == 2'd3 && last_word) begin
                    state_nx = CHK;
                end
            end
            CHK: begin
                if (xfer) begin
                    state_nx = (bs.byte_data == xor_q) ? RUN : ERR;
                end
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            words_written <= '0;
            len_lo        <= '0;
            n_words       <= '0;
            byte_idx      <= '0;
            asm_q         <= '0;
            xor_q         <= '0;
        end else begin
            imem_we <= 1'b0;
            if (state == IDLE && start) begin
                xor_q         <= '0;
                words_written <= '0;
                byte_idx      <= '0;
            end
            if (xfer) begin
                case (state)
                    LEN0: len_lo  <= bs.byte_data;
                    LEN1: n_words <= len_full[ADDR_WIDTH:0];
                    DATA: begin
                        xor_q    <= xor_q ^ bs.byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we       <= 1'b1;
                            imem_addr     <= words_written[ADDR_WIDTH-1:0];
                            imem_wdata    <= {bs.byte_data, asm_q};
                            words_written <= words_written + ONE;
                        end else begin
                            // LSB-first: older bytes drift toward bit 0.
                            asm_q <= {bs.byte_data, asm_q[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of `risc_top`'s instruction memory. Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0. After the frame checksum verifies, it asserts `load` to release the core, which begins fetching from PC = 0. A bad frame latches `error` and keeps the core held.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: instruction-memory word-address width; capacity = 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `areset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins frame reception. Honoured only in IDLE.
- `byte_valid`  in  1  upstream byte available.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_WIDTH  word address for the write.
- `imem_wdata`  out  32  instruction word.
- `load`  out  1  core run enable to `risc_top`; sticky until reset.
- `error`  out  1  frame rejected; sticky until reset.
- `busy`  out  1  high in LEN0, LEN1, DATA, CHK.
- `words_written`  out  ADDR_WIDTH+1  count of words written this frame.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N data bytes (each word LSB first), then CHK = XOR of all 4N data bytes only (length bytes excluded).
- A byte transfers on a rising edge when `byte_valid && byte_ready`.
- FSM states: IDLE, LEN0, LEN1, DATA, CHK, RUN, ERR.
  - IDLE -> LEN0 on `start`.
  - LEN0 -> LEN1 on transfer; capture LEN_LO.
  - LEN1, on transfer:
    - N > 2^ADDR_WIDTH -> ERR.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
  - DATA: shift bytes into a 32-bit assembler, tracked by a 2-bit byte index.
    - On the 4th byte of a word, issue a write; `words_written` increments in the same cycle as the strobe.
    - After word N-1's 4th byte -> CHK.
  - CHK, on transfer: byte == running XOR -> RUN, else -> ERR.
  - RUN and ERR are terminal until `areset`.
- `byte_ready` = 1 exactly in LEN0, LEN1, DATA, CHK, decoded from the state register. It is 0 in IDLE, RUN, ERR.
- `start` is ignored outside IDLE, including mid-frame.
- Running XOR and `words_written` clear on entry to LEN0.
- Memory contents are never cleared by the loader.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load`=0, `error`=0, `busy`=0, `words_written`=0; state = IDLE.
- Reset mid-frame returns to IDLE in the next cycle. Partially assembled words are discarded, and no `imem_we` is issued after the reset edge.
- `imem_we` is a registered one-cycle pulse, high in the cycle after the 4th-byte handshake. `imem_addr` and `imem_wdata` are valid in that same cycle and hold their values until the next write.
- Write k (0-based) targets address k. The maximum address is 2^ADDR_WIDTH-1; addresses never wrap, because the length check forbids it.
- `load` or `error` rises in the cycle after the CHK handshake.
- `busy` falls in that same cycle.
- Back-to-back bytes are accepted every cycle. Gaps in `byte_valid` stall the FSM with no state change.

## Test plan
- Reset: hold `areset`=1 for 2 cycles with `byte_valid`=1 -> every output is 0 and no handshake occurs.
- Good frame: `start`, then bytes 02 00 93 00 50 00 13 01 A0 00 71 back-to-back ->
  - write addr 0 = 0x00500093, then addr 1 = 0x00A00113;
  - `words_written`=2;
  - `load`=1 one cycle after the 0x71 handshake; `error`=0;
  - `byte_ready`=0 thereafter.
- Bad checksum: same frame ending in 0x70 -> both writes occur, `error`=1, `load`=0, `byte_ready` stays 0.
- Empty and oversize: frame 00 00 00 -> no `imem_we`, `load`=1. After reset, frame 01 01 (N=257, ADDR_WIDTH=8) -> `error`=1 the cycle after LEN_HI, with no writes.
- Stall and restart:
  - Good frame with `byte_valid` toggling every other cycle -> identical writes and result.
  - Second run: assert `areset` after 5 data bytes -> exactly one write (addr 0), state IDLE, `words_written`=0.
  - Then a fresh `start` and the full good frame -> `load`=1.
- Ignored start: pulse `start` during DATA and in RUN -> no state change, no counter clear.
